// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank.
// Contents: S=R=1 resolution mode constants, the 2-bit mode type and the
// per-channel next-state function used by every sr_ff_cell.
package sr_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t SR_MODE_HOLD = 2'd0;
  localparam sr_mode_t SR_MODE_SET  = 2'd1;
  localparam sr_mode_t SR_MODE_RST  = 2'd2;
  localparam sr_mode_t SR_MODE_TOG  = 2'd3;

  // Next q for one channel given its sampled controls.
  function automatic logic sr_next(input sr_mode_t mode, input logic q, input logic en,
                                   input logic s, input logic r);
    logic nq;
    nq = q;
    if (en) begin
      case ({s, r})
        2'b10:   nq = 1'b1;
        2'b01:   nq = 1'b0;
        2'b11: begin
          case (mode)
            SR_MODE_SET: nq = 1'b1;
            SR_MODE_RST: nq = 1'b0;
            SR_MODE_TOG: nq = ~q;
            default:     nq = q;
          endcase
        end
        default: nq = q;
      endcase
    end
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR flip-flop channel.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, forces q to RESET_VAL
//   en   - channel enable; q only changes when en=1
//   s, r - set / reset requests
//   q    - registered channel state
//   ill  - combinational strobe: en & s & r this cycle
module sr_ff_cell
  import sr_pkg::*;
#(
  parameter int unsigned MODE      = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic ill
);

  localparam sr_mode_t LP_MODE  = sr_mode_t'(MODE);
  localparam logic     LP_RST_Q = 1'(RESET_VAL);

  logic r_q;
  logic w_q_d;

  always_comb begin
    w_q_d = sr_next(LP_MODE, r_q, en, s, r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= LP_RST_Q;
    end else begin
      r_q <= w_q_d;
    end
  end

  assign q   = r_q;
  assign ill = en & s & r;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N independent clocked SR flip-flops with sticky illegal-input
// flags and a saturating illegal-cycle counter.
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset of all state
//   en      - per-channel enable
//   s, r    - per-channel set / reset
//   clr_err - synchronous clear of err and err_cnt (new events still win)
//   q       - registered channel state
//   qbar    - ~q, no separate flop
//   err     - sticky per-channel flag for en=s=r=1
//   err_cnt - saturating count of cycles with any illegal channel
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MODE      = 0,
  parameter int unsigned RESET_VAL = 0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     en,
  input  logic [N-1:0]     s,
  input  logic [N-1:0]     r,
  input  logic             clr_err,
  output logic [N-1:0]     q,
  output logic [N-1:0]     qbar,
  output logic [N-1:0]     err,
  output logic [CNT_W-1:0] err_cnt
);

  if (N < 1 || N > 32 || MODE > 3 || CNT_W < 1 || RESET_VAL > 1) begin : g_bad_param
    $error("sr_ff_bank: illegal parameters N=%0d MODE=%0d RESET_VAL=%0d CNT_W=%0d",
           N, MODE, RESET_VAL, CNT_W);
  end

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic [N-1:0]     w_q;
  logic [N-1:0]     w_ill;
  logic             w_any_ill;
  logic [N-1:0]     w_err_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [N-1:0]     r_err;
  logic [CNT_W-1:0] r_err_cnt;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sr_ff_cell #(
      .MODE      (MODE),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en[i]),
      .s   (s[i]),
      .r   (r[i]),
      .q   (w_q[i]),
      .ill (w_ill[i])
    );
  end

  // Several illegal channels in one cycle count as a single event.
  assign w_any_ill = |w_ill;

  always_comb begin
    // Clear first, then OR in this cycle's events so a coincident event survives.
    w_err_d = clr_err ? '0 : r_err;
    w_err_d = w_err_d | w_ill;

    w_cnt_d = r_err_cnt;
    if (clr_err) begin
      w_cnt_d = w_any_ill ? LP_CNT_ONE : '0;
    end else if (w_any_ill && (r_err_cnt != LP_CNT_MAX)) begin
      w_cnt_d = r_err_cnt + LP_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err     <= w_err_d;
      r_err_cnt <= w_cnt_d;
    end
  end

  assign q       = w_q;
  assign qbar    = ~w_q;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank. Drives one stimulus stream into a main
// bank (N=4, MODE=0), four single-channel banks (MODE 0..3, fed from bit 0)
// and a narrow-counter bank (CNT_W=3); expected outputs are queued at drive
// time and compared after the capturing edge.
`timescale 1ns/1ps
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_err = 1'b0;
  logic [3:0] en = '0;
  logic [3:0] s  = '0;
  logic [3:0] r  = '0;

  always #5 clk = ~clk;

  // Main bank
  logic [3:0] q_m, qb_m, err_m;
  logic [7:0] cnt_m;
  // Saturation bank
  logic [3:0] q_s, qb_s, err_s;
  logic [2:0] cnt_s;
  // Mode banks, bit k = mode k
  wire  [3:0] q_md, qb_md, err_md;
  wire  [7:0] cnt_md [4];

  sr_ff_bank #(.N(4), .MODE(0), .RESET_VAL(0), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_m), .qbar(qb_m), .err(err_m), .err_cnt(cnt_m)
  );

  sr_ff_bank #(.N(4), .MODE(0), .RESET_VAL(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
    .q(q_s), .qbar(qb_s), .err(err_s), .err_cnt(cnt_s)
  );

  for (genvar k = 0; k < 4; k++) begin : g_mode
    sr_ff_bank #(.N(1), .MODE(k), .RESET_VAL(0), .CNT_W(8)) u_mode (
      .clk(clk), .rst(rst), .en(en[0:0]), .s(s[0:0]), .r(r[0:0]), .clr_err(clr_err),
      .q(q_md[k:k]), .qbar(qb_md[k:k]), .err(err_md[k:k]), .err_cnt(cnt_md[k])
    );
  end

  typedef struct packed {
    logic [3:0]  q;
    logic [3:0]  err;
    logic [7:0]  cnt;
    logic [2:0]  scnt;
    logic [3:0]  mq;
    logic [3:0]  merr;
    logic [31:0] mcnt;
  } exp_t;

  exp_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  logic [3:0] m_q, m_err, md_q, md_err;
  int         m_cnt, m_scnt;
  int         md_cnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic nxt(input int mode, input logic q, input logic e, input logic ss,
                               input logic rr);
    if (!e) return q;
    if (ss && !rr) return 1'b1;
    if (!ss && rr) return 1'b0;
    if (!ss && !rr) return q;
    case (mode)
      1: return 1'b1;
      2: return 1'b0;
      3: return ~q;
      default: return q;
    endcase
  endfunction

  function automatic int cnt_next(input int cur, input logic c, input logic any, input int max);
    if (c) return any ? 1 : 0;
    if (any && cur < max) return cur + 1;
    return cur;
  endfunction

  task automatic model_reset();
    m_q = '0; m_err = '0; m_cnt = 0; m_scnt = 0;
    md_q = '0; md_err = '0;
    for (int k = 0; k < 4; k++) md_cnt[k] = 0;
  endtask

  task automatic compare();
    exp_t       x;
    logic [3:0] inv;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    inv = ~x.q;
    check("q", 32'(q_m), 32'(x.q));
    check("qbar", 32'(qb_m), 32'(inv));
    check("err", 32'(err_m), 32'(x.err));
    check("err_cnt", 32'(cnt_m), 32'(x.cnt));
    check("sat_q", 32'(q_s), 32'(x.q));
    check("sat_err_cnt", 32'(cnt_s), 32'(x.scnt));
    check("mode_q", 32'(q_md), 32'(x.mq));
    inv = ~x.mq;
    check("mode_qbar", 32'(qb_md), 32'(inv));
    check("mode_err", 32'(err_md), 32'(x.merr));
    check("mode_cnt", {cnt_md[3], cnt_md[2], cnt_md[1], cnt_md[0]}, x.mcnt);
  endtask

  task automatic step(input logic [3:0] e, input logic [3:0] ss, input logic [3:0] rr,
                      input logic c);
    exp_t       x;
    logic [3:0] ill;
    @(negedge clk);
    en = e; s = ss; r = rr; clr_err = c;
    ill = e & ss & rr;
    for (int i = 0; i < 4; i++) m_q[i] = nxt(0, m_q[i], e[i], ss[i], rr[i]);
    m_err  = (c ? 4'b0 : m_err) | ill;
    m_cnt  = cnt_next(m_cnt, c, |ill, 255);
    m_scnt = cnt_next(m_scnt, c, |ill, 7);
    for (int k = 0; k < 4; k++) begin
      md_q[k]   = nxt(k, md_q[k], e[0], ss[0], rr[0]);
      md_err[k] = (c ? 1'b0 : md_err[k]) | ill[0];
      md_cnt[k] = cnt_next(md_cnt[k], c, ill[0], 255);
    end
    x.q = m_q; x.err = m_err; x.cnt = 8'(m_cnt); x.scnt = 3'(m_scnt);
    x.mq = md_q; x.merr = md_err;
    x.mcnt = {8'(md_cnt[3]), 8'(md_cnt[2]), 8'(md_cnt[1]), 8'(md_cnt[0])};
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare();
  endtask

  // Short reset pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_q", 32'(q_m), 32'h0);
    check("rst_qbar", 32'(qb_m), 32'hF);
    check("rst_err", 32'(err_m), 32'h0);
    check("rst_err_cnt", 32'(cnt_m), 32'h0);
    check("rst_sat_cnt", 32'(cnt_s), 32'h0);
    check("rst_mode_q", 32'(q_md), 32'h0);
    check("rst_mode_err", 32'(err_md), 32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Basic set/reset and hold
    reset_pulse();
    step(4'b1111, 4'b0101, 4'b1010, 1'b0);
    check("set_q_0101", 32'(q_m), 32'h5);
    repeat (3) step(4'b1111, 4'b0000, 4'b0000, 1'b0);
    check("hold_q_0101", 32'(q_m), 32'h5);

    // Enable gating
    reset_pulse();
    step(4'b0011, 4'b1111, 4'b0000, 1'b0);
    check("gate_q_0011", 32'(q_m), 32'h3);
    step(4'b0011, 4'b1100, 4'b1100, 1'b0);
    check("gate_err_0000", 32'(err_m), 32'h0);
    check("gate_cnt_0", 32'(cnt_m), 32'h0);

    // Mode sweep on channel 0
    reset_pulse();
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    check("mode_edge1_q", 32'(q_md), 32'hA);
    check("mode_edge1_err", 32'(err_md), 32'hF);
    step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    check("mode_edge2_q", 32'(q_md), 32'h2);

    // Sticky flags and counter
    reset_pulse();
    repeat (5) step(4'b0101, 4'b0101, 4'b0101, 1'b0);
    check("err_0101", 32'(err_m), 32'h5);
    check("cnt_5", 32'(cnt_m), 32'd5);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check("clr_err_0", 32'(err_m), 32'h0);
    check("clr_cnt_0", 32'(cnt_m), 32'd0);
    step(4'b0010, 4'b0010, 4'b0010, 1'b1);
    check("clr_ev_err_0010", 32'(err_m), 32'h2);
    check("clr_ev_cnt_1", 32'(cnt_m), 32'd1);

    // Saturation of the 3-bit counter
    reset_pulse();
    for (int i = 1; i <= 10; i++) begin
      step(4'b1111, 4'b1111, 4'b1111, 1'b0);
      if (i >= 7) check("sat_cnt_7", 32'(cnt_s), 32'd7);
    end

    // Reset mid-operation
    reset_pulse();
    step(4'b1111, 4'b1111, 4'b0000, 1'b0);
    repeat (4) step(4'b0001, 4'b0001, 4'b0001, 1'b0);
    check("pre_rst_q", 32'(q_m), 32'hF);
    check("pre_rst_cnt", 32'(cnt_m), 32'd4);
    reset_pulse();
    step(4'b1111, 4'b1111, 4'b0000, 1'b0);
    check("post_rst_q", 32'(q_m), 32'hF);
    check("post_rst_cnt", 32'(cnt_m), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
